fetch_pc_redirect_unit: RTL and testbench

IF-stage next-PC generator that consumes the branch handler's outputs: br_prediction, jump_detected, flush and branch_hazard_stall. It holds the fetch PC and computes the beq and j targets from the IF instruction. It pipelines the alternate-path (recovery) PC alongside each predicted beq into ID, and redirects fetch to it on a misprediction flush. It also drives the low PC bits that index the predictor and keeps saturating branch and mispredict counters.

---
 rtl/fetch_pc_redirect_if.sv | 34 +++
 rtl/fetch_pc_redirect_unit.sv | 126 ++++++++++++
 tb/tb_fetch_pc_redirect_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_redirect_if.sv
// Fetch-stage bundle between the branch handler / hazard units and the PC redirect unit.
// The master drives instruction and control; the slave returns fetch PC, status and counters.
interface fetch_pc_redirect_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [31:0]      instr_IF;
    logic             br_prediction;
    logic             jump_detected;
    logic             branch_hazard_stall;
    logic             load_use_stall;
    logic             flush;
    logic [PC_W-1:0]  pc_IF;
    logic [4:0]       branch_addr_lw_5b;
    logic             ifid_flush;
    logic [1:0]       redirect_state;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] spurious_flush_cnt;

    modport master (
        output instr_IF, br_prediction, jump_detected, branch_hazard_stall,
               load_use_stall, flush,
        input  pc_IF, branch_addr_lw_5b, ifid_flush, redirect_state,
               branch_cnt, mispredict_cnt, spurious_flush_cnt
    );

    modport slave (
        input  instr_IF, br_prediction, jump_detected, branch_hazard_stall,
               load_use_stall, flush,
        output pc_IF, branch_addr_lw_5b, ifid_flush, redirect_state,
               branch_cnt, mispredict_cnt, spurious_flush_cnt
    );
endinterface

// File: rtl/fetch_pc_redirect_unit.sv
// IF-stage next-PC generator: sequential/jump/predicted-branch targets, stall hold,
// misprediction recovery through a PC carried alongside each beq into ID, and saturating counters.
//
// state   | meaning
// RUN     | normal fetch
// HOLD    | fetch PC frozen by a stall
// RECOVER | one cycle after an accepted flush; ID holds a killed bubble
module fetch_pc_redirect_unit #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_pc_redirect_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  recovery_pc_q, recovery_pc_d;
    logic             br_valid_q, br_valid_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
    logic [CNT_W-1:0] spurious_cnt_q, spurious_cnt_d;

    logic             is_beq_IF;
    logic             stall;
    logic             flush_ok;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  br_offset;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  j_target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (en && (v != {CNT_W{1'b1}})) ? v + one : v;
    endfunction

    assign is_beq_IF = (bus.instr_IF[31:26] == 6'b000100);
    assign stall     = bus.branch_hazard_stall | bus.load_use_stall;
    // A flush in RECOVER targets the bubble we already killed, so it must not redirect again.
    assign flush_ok  = bus.flush & br_valid_q & (state_q != RECOVER);
    assign pc_plus4  = pc_q + 4;
    assign br_offset = {{(PC_W-18){bus.instr_IF[15]}}, bus.instr_IF[15:0], 2'b00};
    assign br_target = pc_plus4 + br_offset;
    assign j_target  = {pc_plus4[PC_W-1:PC_W-4], bus.instr_IF[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, HOLD: begin
                if (flush_ok)   state_d = RECOVER;
                else if (stall) state_d = HOLD;
                else            state_d = RUN;
            end
            RECOVER: state_d = stall ? HOLD : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.redirect_state = state_q;
        bus.ifid_flush     = flush_ok & rst_n;
    end

    always_comb begin
        pc_d          = pc_plus4;
        recovery_pc_d = recovery_pc_q;
        br_valid_d    = br_valid_q;
        if (flush_ok) begin
            pc_d       = recovery_pc_q;
            br_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            if (bus.jump_detected)                    pc_d = j_target;
            else if (is_beq_IF && bus.br_prediction)  pc_d = br_target;
            br_valid_d    = is_beq_IF;
            recovery_pc_d = bus.br_prediction ? pc_plus4 : br_target;
        end
    end

    always_comb begin
        branch_cnt_d     = sat_inc(branch_cnt_q, is_beq_IF & ~stall & ~flush_ok);
        mispredict_cnt_d = sat_inc(mispredict_cnt_q, flush_ok);
        spurious_cnt_d   = sat_inc(spurious_cnt_q, bus.flush & ~flush_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC[PC_W-1:0];
            recovery_pc_q    <= '0;
            br_valid_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            spurious_cnt_q   <= '0;
        end else begin
            pc_q             <= pc_d;
            recovery_pc_q    <= recovery_pc_d;
            br_valid_q       <= br_valid_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            spurious_cnt_q   <= spurious_cnt_d;
        end
    end

    assign bus.pc_IF              = pc_q;
    assign bus.branch_addr_lw_5b  = pc_q[6:2];
    assign bus.branch_cnt         = branch_cnt_q;
    assign bus.mispredict_cnt     = mispredict_cnt_q;
    assign bus.spurious_flush_cnt = spurious_cnt_q;
endmodule

// File: tb/tb_fetch_pc_redirect_unit.sv
// Directed bench for fetch_pc_redirect_unit: a low-reset-PC instance with 4-bit counters
// for flow and saturation, and a high-reset-PC instance for jump target upper bits.
module tb_fetch_pc_redirect_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    always #5 clk = ~clk;

    fetch_pc_redirect_if #(.PC_W(32), .CNT_W(4))  m ();
    fetch_pc_redirect_if #(.PC_W(32), .CNT_W(16)) h ();

    fetch_pc_redirect_unit #(.PC_W(32), .RESET_PC(32'h0000_0100), .CNT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    fetch_pc_redirect_unit #(.PC_W(32), .RESET_PC(32'h1000_0040), .CNT_W(16)) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (h)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'b000100, 5'd0, 5'd0, imm};
    endfunction

    function automatic logic [31:0] jmp(input logic [25:0] idx);
        return {6'b000010, idx};
    endfunction

    task automatic drv_m(input logic [31:0] instr, input logic pred, input logic jd,
                         input logic bhs, input logic lus, input logic fl);
        m.instr_IF            = instr;
        m.br_prediction       = pred;
        m.jump_detected       = jd;
        m.branch_hazard_stall = bhs;
        m.load_use_stall      = lus;
        m.flush               = fl;
        #1;
    endtask

    task automatic drv_h(input logic [31:0] instr, input logic jd, input logic lus);
        h.instr_IF            = instr;
        h.br_prediction       = 1'b0;
        h.jump_detected       = jd;
        h.branch_hazard_stall = 1'b0;
        h.load_use_stall      = lus;
        h.flush               = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv_m(NOP, 0, 0, 0, 0, 0);
        drv_h(NOP, 0, 1);
        tick();
        tick();
        chk("rst_pc",    m.pc_IF, 32'h100);
        chk("rst_state", 32'(m.redirect_state), 0);
        chk("rst_bcnt",  32'(m.branch_cnt), 0);
        chk("rst_mcnt",  32'(m.mispredict_cnt), 0);
        chk("rst_scnt",  32'(m.spurious_flush_cnt), 0);
        chk("hi_rst_pc", h.pc_IF, 32'h1000_0040);
        chk("hi_rst_lw5", 32'(h.branch_addr_lw_5b), 32'h10);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc",   m.pc_IF, 32'h100 + 32'(4 * i));
            chk("seq_lw5",  32'(m.branch_addr_lw_5b), 32'(i));
            chk("seq_ifid", 32'(m.ifid_flush), 0);
            if (i < 3) tick();
        end

        drv_m(jmp(26'h80), 0, 1, 0, 0, 0);
        tick();
        chk("j_to_200", m.pc_IF, 32'h200);

        // predicted-taken beq, then mispredict flush back to the fall-through
        drv_m(beq(16'h0004), 1, 0, 0, 0, 0);
        tick();
        chk("beq_taken_pc", m.pc_IF, 32'h214);
        chk("beq_taken_bcnt", 32'(m.branch_cnt), 1);
        drv_m(NOP, 0, 0, 0, 0, 1);
        chk("flush1_ifid", 32'(m.ifid_flush), 1);
        tick();
        chk("flush1_pc", m.pc_IF, 32'h204);
        chk("flush1_mcnt", 32'(m.mispredict_cnt), 1);
        chk("flush1_state", 32'(m.redirect_state), 2);
        drv_m(NOP, 0, 0, 0, 0, 0);
        tick();
        chk("rec1_state", 32'(m.redirect_state), 0);
        chk("rec1_pc", m.pc_IF, 32'h208);

        // not-taken backward beq, flush to its target, then a flush while in RECOVER
        drv_m(jmp(26'hC0), 0, 1, 0, 0, 0);
        tick();
        chk("j_to_300", m.pc_IF, 32'h300);
        drv_m(beq(16'hFFFE), 0, 0, 0, 0, 0);
        tick();
        chk("beq_nt_pc", m.pc_IF, 32'h304);
        chk("beq_nt_bcnt", 32'(m.branch_cnt), 2);
        drv_m(NOP, 0, 0, 0, 0, 1);
        chk("flush2_ifid", 32'(m.ifid_flush), 1);
        tick();
        chk("flush2_pc", m.pc_IF, 32'h2FC);
        chk("flush2_state", 32'(m.redirect_state), 2);
        chk("flush2_mcnt", 32'(m.mispredict_cnt), 2);
        drv_m(NOP, 0, 0, 0, 0, 1);
        chk("recflush_ifid", 32'(m.ifid_flush), 0);
        tick();
        chk("recflush_pc", m.pc_IF, 32'h300);
        chk("recflush_scnt", 32'(m.spurious_flush_cnt), 1);
        chk("recflush_mcnt", 32'(m.mispredict_cnt), 2);
        chk("recflush_state", 32'(m.redirect_state), 0);

        // load-use stall with a beq in IF, then flush during a stall
        drv_m(beq(16'h0001), 1, 0, 0, 1, 0);
        tick();
        chk("stall1_pc", m.pc_IF, 32'h300);
        chk("stall1_state", 32'(m.redirect_state), 1);
        chk("stall1_bcnt", 32'(m.branch_cnt), 2);
        tick();
        chk("stall2_pc", m.pc_IF, 32'h300);
        chk("stall2_state", 32'(m.redirect_state), 1);
        drv_m(beq(16'h0001), 1, 0, 0, 0, 0);
        tick();
        chk("unstall_pc", m.pc_IF, 32'h308);
        chk("unstall_state", 32'(m.redirect_state), 0);
        chk("unstall_bcnt", 32'(m.branch_cnt), 3);
        drv_m(NOP, 0, 0, 0, 1, 0);
        tick();
        chk("hold_pc", m.pc_IF, 32'h308);
        chk("hold_state", 32'(m.redirect_state), 1);
        drv_m(NOP, 0, 0, 0, 1, 1);
        chk("stflush_ifid", 32'(m.ifid_flush), 1);
        tick();
        chk("stflush_pc", m.pc_IF, 32'h304);
        chk("stflush_state", 32'(m.redirect_state), 2);
        chk("stflush_mcnt", 32'(m.mispredict_cnt), 3);
        drv_m(NOP, 0, 0, 1, 0, 0);
        tick();
        chk("rec_to_hold_state", 32'(m.redirect_state), 1);
        chk("rec_to_hold_pc", m.pc_IF, 32'h304);
        drv_m(NOP, 0, 0, 0, 0, 0);
        tick();
        chk("hold_to_run_state", 32'(m.redirect_state), 0);
        chk("hold_to_run_pc", m.pc_IF, 32'h308);

        // flush with nothing tracked in ID
        drv_m(NOP, 0, 0, 0, 0, 1);
        chk("spur_ifid", 32'(m.ifid_flush), 0);
        tick();
        chk("spur_pc", m.pc_IF, 32'h30C);
        chk("spur_scnt", 32'(m.spurious_flush_cnt), 2);

        // drive counters into saturation (4-bit instance)
        for (int k = 0; k < 13; k++) begin
            drv_m(beq(16'h0000), 1, 0, 0, 0, 0);
            tick();
            drv_m(NOP, 0, 0, 0, 0, 1);
            tick();
            drv_m(NOP, 0, 0, 0, 0, 0);
            tick();
            if (k == 11) begin
                chk("sat_mcnt_full", 32'(m.mispredict_cnt), 32'hF);
                chk("sat_bcnt_full", 32'(m.branch_cnt), 32'hF);
            end
        end
        chk("sat_mcnt_hold", 32'(m.mispredict_cnt), 32'hF);
        chk("sat_bcnt_hold", 32'(m.branch_cnt), 32'hF);
        chk("sat_pc", m.pc_IF, 32'h374);

        // reset with a recovery pending discards it
        drv_m(beq(16'h0004), 1, 0, 0, 0, 0);
        tick();
        chk("pre_rst_pc", m.pc_IF, 32'h388);
        rst_n = 1'b0;
        drv_m(NOP, 0, 0, 0, 0, 1);
        chk("rst_ifid", 32'(m.ifid_flush), 0);
        tick();
        chk("midrst_pc", m.pc_IF, 32'h100);
        chk("midrst_mcnt", 32'(m.mispredict_cnt), 0);
        chk("midrst_bcnt", 32'(m.branch_cnt), 0);
        chk("midrst_state", 32'(m.redirect_state), 0);
        rst_n = 1'b1;
        #1;
        chk("postrst_ifid", 32'(m.ifid_flush), 0);
        tick();
        chk("postrst_pc", m.pc_IF, 32'h104);
        chk("postrst_scnt", 32'(m.spurious_flush_cnt), 1);
        chk("postrst_mcnt", 32'(m.mispredict_cnt), 0);
        drv_m(NOP, 0, 0, 0, 0, 0);

        // jump targets keep the upper nibble of pc+4
        chk("hi_held_pc", h.pc_IF, 32'h1000_0040);
        drv_h(jmp(26'h10), 1, 0);
        chk("hi_j_ifid", 32'(h.ifid_flush), 0);
        tick();
        chk("hi_j10_pc", h.pc_IF, 32'h1000_0040);
        drv_h(jmp(26'h20), 1, 0);
        tick();
        chk("hi_j20_pc", h.pc_IF, 32'h1000_0080);
        chk("hi_j20_ifid", 32'(h.ifid_flush), 0);
        chk("hi_bcnt", 32'(h.branch_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
